// File: rtl/ultrasound_delay_pkg.sv
// Shared types and constants for the element term sequencer.
// TERM_SATURATE_EN widens the accumulator guard so add/subtract results can be clamped.
package ultrasound_delay_pkg;

    localparam int DW_INTEGER_DEF  = 18;
    localparam int DW_FRACTION_DEF = 3;
    localparam int TERM_W          = DW_INTEGER_DEF + DW_FRACTION_DEF + 1;

    typedef logic signed [TERM_W-1:0] term_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } seq_state_t;

    localparam term_t TERM_MAX = {1'b0, {(TERM_W-1){1'b1}}};
    localparam term_t TERM_MIN = {1'b1, {(TERM_W-1){1'b0}}};

`ifdef TERM_SATURATE_EN
    // Three guard bits hold a0 + |c0| and term + 2*a0 without overflow.
    localparam int TERM_GUARD = 3;
`else
    localparam int TERM_GUARD = 0;
`endif

endpackage

// File: rtl/term_accumulator.sv
// Registered term that either loads a start value or adds a step each advance.
// With TERM_SATURATE_EN the result clamps to the signed range and reports it on sat.
module term_accumulator
    import ultrasound_delay_pkg::*;
#(
    parameter int W  = TERM_W,
    parameter int XW = W + TERM_GUARD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 advance,
    input  logic signed [XW-1:0] load_value,
    input  logic signed [XW-1:0] step_value,
    output logic signed [W-1:0]  term
`ifdef TERM_SATURATE_EN
    ,
    output logic                 sat
`endif
);

    logic signed [XW-1:0] sum_s;
    logic signed [W-1:0]  term_next_s;

`ifdef TERM_SATURATE_EN
    localparam logic signed [XW-1:0] SAT_MAX_X = XW'({1'b0, {(W-1){1'b1}}});
    localparam logic signed [XW-1:0] SAT_MIN_X = ~SAT_MAX_X;
    logic sat_s;

    assign sat = sat_s & (load | advance);
`endif

    // Select load or accumulate, then clamp or wrap into the term width
    always_comb begin
        sum_s       = '0;
        term_next_s = '0;
        if (load) begin
            sum_s = load_value;
        end else begin
            sum_s = XW'(term) + step_value;
        end
`ifdef TERM_SATURATE_EN
        sat_s = 1'b0;
        if (sum_s > SAT_MAX_X) begin
            term_next_s = {1'b0, {(W-1){1'b1}}};
            sat_s       = 1'b1;
        end else if (sum_s < SAT_MIN_X) begin
            term_next_s = {1'b1, {(W-1){1'b0}}};
            sat_s       = 1'b1;
        end else begin
            term_next_s = W'(sum_s);
            sat_s       = 1'b0;
        end
`else
        term_next_s = W'(sum_s);
`endif
    end

    // Term register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            term <= '0;
        end else if (load || advance) begin
            term <= term_next_s;
        end else begin
            term <= term;
        end
    end

endmodule

// File: rtl/element_term_sequencer.sv
// Streams K_n = A_0(2n+1) -/+ C_0 pairs for a symmetric array over a valid/ack handshake.
// TERM_SATURATE_EN: saturating arithmetic plus a sticky per-sequence sat_flag output.
module element_term_sequencer
    import ultrasound_delay_pkg::*;
#(
    parameter int DW_INTEGER   = DW_INTEGER_DEF,
    parameter int DW_FRACTION  = DW_FRACTION_DEF,
    parameter int MAX_ELEMENTS = 32,
    parameter int IDX_W        = $clog2(MAX_ELEMENTS),
    parameter int CNT_W        = $clog2(MAX_ELEMENTS + 1),
    localparam int W           = DW_INTEGER + DW_FRACTION + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                initiate,
    input  logic [CNT_W-1:0]    num_elements,
    input  logic [W-1:0]        a_0,
    input  logic signed [W-1:0] c_0,
    input  logic                ack,
    output logic signed [W-1:0] term_pos,
    output logic signed [W-1:0] term_neg,
    output logic [IDX_W-1:0]    index,
    output logic                last,
    output logic                valid,
    output logic                busy,
    output logic                done
`ifdef TERM_SATURATE_EN
    ,
    output logic                sat_flag
`endif
);

    localparam int XW = W + TERM_GUARD;

    seq_state_t           state_r, state_next_s;
    logic [CNT_W-1:0]     count_r, count_in_s, idx_inc_s;
    logic [W-1:0]         a0_r;
    logic signed [W-1:0]  c0_r;
    logic signed [XW-1:0] step_r, a0_ext_s, c0_ext_s, pos_load_s, neg_load_s;
    logic [IDX_W-1:0]     index_r, index_next_s;
    logic                 last_r, last_next_s, valid_r, valid_next_s;
    logic                 done_r, done_next_s, busy_r;
    logic                 latch_s, load_s, advance_s;

    assign count_in_s = (num_elements > CNT_W'(MAX_ELEMENTS)) ? CNT_W'(MAX_ELEMENTS) : num_elements;
    assign idx_inc_s  = CNT_W'(index_r) + CNT_W'(1);
    assign a0_ext_s   = $signed(XW'(a0_r));
    assign c0_ext_s   = XW'(c0_r);
    assign pos_load_s = a0_ext_s - c0_ext_s;
    assign neg_load_s = a0_ext_s + c0_ext_s;

    // Next-state and handshake decode
    always_comb begin
        state_next_s = state_r;
        latch_s      = 1'b0;
        load_s       = 1'b0;
        advance_s    = 1'b0;
        done_next_s  = 1'b0;
        valid_next_s = valid_r;
        index_next_s = index_r;
        last_next_s  = last_r;
        case (state_r)
            IDLE: begin
                if (initiate && (num_elements != '0)) begin
                    latch_s      = 1'b1;
                    state_next_s = LOAD;
                end else if (initiate) begin
                    done_next_s  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                load_s       = 1'b1;
                valid_next_s = 1'b1;
                index_next_s = '0;
                last_next_s  = (count_r == CNT_W'(1));
                state_next_s = STREAM;
            end
            STREAM: begin
                if (valid_r && ack && last_r) begin
                    valid_next_s = 1'b0;
                    done_next_s  = 1'b1;
                    state_next_s = IDLE;
                end else if (valid_r && ack) begin
                    advance_s    = 1'b1;
                    index_next_s = index_r + IDX_W'(1);
                    last_next_s  = (idx_inc_s == (count_r - CNT_W'(1)));
                end else begin
                    state_next_s = STREAM;
                end
            end
            default: begin
                state_next_s = IDLE;
                valid_next_s = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Latched operands, step and handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
            a0_r    <= '0;
            c0_r    <= '0;
            step_r  <= '0;
            index_r <= '0;
            last_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            if (latch_s) begin
                count_r <= count_in_s;
                a0_r    <= a_0;
                c0_r    <= c_0;
            end else begin
                count_r <= count_r;
                a0_r    <= a0_r;
                c0_r    <= c0_r;
            end
            step_r  <= load_s ? XW'({a0_r, 1'b0}) : step_r;
            index_r <= index_next_s;
            last_r  <= last_next_s;
            valid_r <= valid_next_s;
            done_r  <= done_next_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

`ifdef TERM_SATURATE_EN
    logic sat_pos_s, sat_neg_s, sat_flag_r;

    // Sticky saturation indicator, restarted by each load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_flag_r <= 1'b0;
        end else if (load_s) begin
            sat_flag_r <= sat_pos_s | sat_neg_s;
        end else if (advance_s) begin
            sat_flag_r <= sat_flag_r | sat_pos_s | sat_neg_s;
        end else begin
            sat_flag_r <= sat_flag_r;
        end
    end

    assign sat_flag = sat_flag_r;
`endif

    term_accumulator #(.W(W), .XW(XW)) u_acc_pos (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .advance    (advance_s),
        .load_value (pos_load_s),
        .step_value (step_r),
        .term       (term_pos)
`ifdef TERM_SATURATE_EN
        ,
        .sat        (sat_pos_s)
`endif
    );

    term_accumulator #(.W(W), .XW(XW)) u_acc_neg (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .advance    (advance_s),
        .load_value (neg_load_s),
        .step_value (step_r),
        .term       (term_neg)
`ifdef TERM_SATURATE_EN
        ,
        .sat        (sat_neg_s)
`endif
    );

    assign index = index_r;
    assign last  = last_r;
    assign valid = valid_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_element_term_sequencer.sv
// Scoreboard bench for element_term_sequencer; expected pairs come from the closed-form K_n.
// Builds with or without TERM_SATURATE_EN.
module tb_element_term_sequencer;

    localparam int W     = 22;
    localparam int MAXE  = 32;
    localparam int IDX_W = 5;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             initiate = 1'b0;
    logic             ack = 1'b0;
    logic [CNT_W-1:0] num_elements = '0;
    logic [W-1:0]     a_0 = '0;
    logic [W-1:0]     c_0 = '0;
    logic [W-1:0]     term_pos, term_neg;
    logic [IDX_W-1:0] index;
    logic             last, valid, busy, done;
`ifdef TERM_SATURATE_EN
    logic             sat_flag;
`endif

    element_term_sequencer #(.MAX_ELEMENTS(MAXE)) dut (
        .clk          (clk),
        .rst          (rst),
        .initiate     (initiate),
        .num_elements (num_elements),
        .a_0          (a_0),
        .c_0          (c_0),
        .ack          (ack),
        .term_pos     (term_pos),
        .term_neg     (term_neg),
        .index        (index),
        .last         (last),
        .valid        (valid),
        .busy         (busy),
        .done         (done)
`ifdef TERM_SATURATE_EN
        ,
        .sat_flag     (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] pos;
        logic [W-1:0] neg;
        int           idx;
        bit           lst;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   hs_count  = 0;
    bit   ack_toggle = 1'b0;
    int   ack_ph    = 0;
    logic [3:0] ack_pat = 4'b1001;

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic longint sat_w(input longint v);
        longint mx = (longint'(1) <<< (W - 1)) - 1;
        longint mn = -(longint'(1) <<< (W - 1));
        if (v > mx) return mx;
        else if (v < mn) return mn;
        else return v;
    endfunction

    function automatic int clamp_n(input int n);
        return (n > MAXE) ? MAXE : n;
    endfunction

    task automatic push_expected(input logic [W-1:0] a0, input logic [W-1:0] c0, input int n);
        int     cnt = clamp_n(n);
        longint a   = longint'(a0);
        longint c   = longint'($signed(c0));
        longint p   = 0;
        longint q   = 0;
        logic [63:0] pv, qv;
        exp_t   e;
        for (int i = 0; i < cnt; i++) begin
`ifdef TERM_SATURATE_EN
            if (i == 0) begin
                p = sat_w(a - c);
                q = sat_w(a + c);
            end else begin
                p = sat_w(p + 2 * a);
                q = sat_w(q + 2 * a);
            end
`else
            p = a * (2 * i + 1) - c;
            q = a * (2 * i + 1) + c;
`endif
            pv = p;
            qv = q;
            e.pos = pv[W-1:0];
            e.neg = qv[W-1:0];
            e.idx = i;
            e.lst = (i == cnt - 1);
            sb.push_back(e);
        end
    endtask

    // Consumer handshake: ack held high or cycling 1-0-0-1
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ack_toggle) begin
                ack    = ack_pat[ack_ph];
                ack_ph = (ack_ph + 1) % 4;
            end else begin
                ack = 1'b1;
            end
        end
    end

    // Every valid cycle must show the oldest outstanding pair; a handshake retires it
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && valid) begin
                if (sb.size() == 0) begin
                    check_value("unexpected_valid", 64'(valid), 64'd0);
                end else begin
                    e = sb[0];
                    check_value("term_pos", 64'(term_pos), 64'(e.pos));
                    check_value("term_neg", 64'(term_neg), 64'(e.neg));
                    check_value("index", 64'(index), 64'(e.idx));
                    check_value("last", 64'(last), 64'(e.lst));
                    if (ack) begin
                        void'(sb.pop_front());
                        hs_count++;
                    end
                end
            end
        end
    end

    task automatic start_seq(input logic [W-1:0] a0, input logic [W-1:0] c0, input int n);
        push_expected(a0, c0, n);
        hs_count = 0;
        @(posedge clk);
        #1;
        a_0 = a0;
        c_0 = c0;
        num_elements = CNT_W'(n);
        initiate = 1'b1;
        @(posedge clk);
        #1;
        initiate = 1'b0;
        a_0 = W'($urandom);
        c_0 = W'($urandom);
        num_elements = CNT_W'($urandom_range(1, 40));
    endtask

    task automatic run_seq(input logic [W-1:0] a0, input logic [W-1:0] c0, input int n,
                           input bit inj_mid, input bit inj_last);
        int cnt   = clamp_n(n);
        int bound = 4 * cnt + 20;
        bit seen  = 1'b0;
        start_seq(a0, c0, n);
        @(negedge clk);
        if (cnt == 0) begin
            check_value("zero_done", 64'(done), 64'd1);
            check_value("zero_busy", 64'(busy), 64'd0);
            check_value("zero_valid", 64'(valid), 64'd0);
            @(negedge clk);
            check_value("zero_done_pulse", 64'(done), 64'd0);
            check_value("zero_busy2", 64'(busy), 64'd0);
        end else begin
            check_value("lat_load_busy", 64'(busy), 64'd1);
            check_value("lat_load_valid", 64'(valid), 64'd0);
            @(negedge clk);
            check_value("lat_valid", 64'(valid), 64'd1);
            for (int k = 0; k < bound && !seen; k++) begin
                initiate = 1'b0;
                if (done) begin
                    seen = 1'b1;
                end else begin
                    if (inj_mid && k == 2) begin
                        initiate = 1'b1;
                        a_0 = 22'd999;
                        c_0 = 22'd5;
                        num_elements = CNT_W'(7);
                    end
                    if (inj_last && valid && last && ack) initiate = 1'b1;
                    @(negedge clk);
                end
            end
            initiate = 1'b0;
            check_value("done_seen", 64'(seen), 64'd1);
            check_value("end_valid", 64'(valid), 64'd0);
            check_value("end_busy", 64'(busy), 64'd0);
            check_value("sb_drained", 64'(sb.size()), 64'd0);
            check_value("handshakes", 64'(hs_count), 64'(cnt));
            @(negedge clk);
            check_value("done_pulse", 64'(done), 64'd0);
            if (inj_mid || inj_last) begin
                repeat (2) @(negedge clk);
                check_value("ignored_busy", 64'(busy), 64'd0);
                check_value("ignored_valid", 64'(valid), 64'd0);
            end
        end
    endtask

    initial begin
        bit hit;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_value("rst_term_pos", 64'(term_pos), 64'd0);
        check_value("rst_term_neg", 64'(term_neg), 64'd0);
        check_value("rst_index", 64'(index), 64'd0);
        check_value("rst_last", 64'(last), 64'd0);
        check_value("rst_valid", 64'(valid), 64'd0);
        check_value("rst_busy", 64'(busy), 64'd0);
        check_value("rst_done", 64'(done), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_value("idle_busy", 64'(busy), 64'd0);

        run_seq(22'd132, 22'd80, 3, 1'b0, 1'b0);
`ifdef TERM_SATURATE_EN
        check_value("sat_flag_clear", 64'(sat_flag), 64'd0);
`endif
        ack_ph = 0;
        ack_toggle = 1'b1;
        run_seq(22'd132, 22'd80, 3, 1'b0, 1'b0);
        ack_toggle = 1'b0;
        run_seq(22'd5, 22'd1, 0, 1'b0, 1'b0);
        run_seq(22'd1000, 22'h3FFFFD, 40, 1'b0, 1'b0);
        run_seq(22'd100, 22'h3FFFF9, 5, 1'b1, 1'b0);
        run_seq(22'd77, 22'd9, 2, 1'b0, 1'b1);

        // Asynchronous reset while streaming index 1
        start_seq(22'd40, 22'd6, 5);
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            if (valid && index == IDX_W'(1)) hit = 1'b1;
        end
        check_value("rst_mid_reached", 64'(hit), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_value("rst_mid_valid", 64'(valid), 64'd0);
        check_value("rst_mid_busy", 64'(busy), 64'd0);
        check_value("rst_mid_done", 64'(done), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_value("rst_rel_busy", 64'(busy), 64'd0);
        check_value("rst_rel_done", 64'(done), 64'd0);
        run_seq(22'd50, 22'd3, 2, 1'b0, 1'b0);

        run_seq(22'h100000, 22'h300000, 4, 1'b0, 1'b0);
`ifdef TERM_SATURATE_EN
        check_value("sat_flag_set", 64'(sat_flag), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/element_term_sequencer.md
Name: element_term_sequencer

Overview:
- Parametrised successor of the per-element comparator-term generator.
- Per transmit event, produces K_n = A_0(2n+1) ∓ C_0 for both sides of a symmetric array (elements +n and −n) over a runtime-programmable element count.
- A_0 and C_0 arrive as runtime inputs; C_0 is the precomputed CORDIC product.
- Streams term pairs to the delay comparators over a valid/ack handshake with backpressure, one pair per cycle when ack is held.

Parameters:
- DW_INTEGER, 18, integer bits of a term.
- DW_FRACTION, 3, fractional bits of a term. Term width W = DW_INTEGER+DW_FRACTION+1, two's complement.
- MAX_ELEMENTS, 32, maximum elements per side, ≥2.
- IDX_W, $clog2(MAX_ELEMENTS), element index width.
- CNT_W, $clog2(MAX_ELEMENTS+1), element count width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- initiate  in  1  start pulse; sampled only in IDLE.
- num_elements  in  CNT_W  elements per side; latched on accepted initiate.
- a_0  in  W  A_0, unsigned fixed point; latched on initiate.
- c_0  in  W  C_0, signed fixed point; latched on initiate.
- ack  in  1  consumer accepts the current pair.
- term_pos  out  W  K_n = A_0(2n+1) − C_0.
- term_neg  out  W  K_n = A_0(2n+1) + C_0.
- index  out  IDX_W  n of the current pair.
- last  out  1  current pair is n = num_elements−1.
- valid  out  1  term_pos, term_neg, index, last are valid.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse at end of sequence.

Behaviour:
- Reset (rst low, async): state=IDLE; all outputs and internal registers 0. Takes effect mid-sequence with no completion pulse.
- States: IDLE, LOAD, STREAM.
- IDLE:
  - initiate=1 and num_elements≠0: latch inputs, go to LOAD.
  - initiate=1 and num_elements=0: no LOAD, done=1 next cycle, stay IDLE.
  - num_elements > MAX_ELEMENTS is clamped to MAX_ELEMENTS at latch.
- LOAD (1 cycle):
  - term_pos ← a_0 − c_0; term_neg ← a_0 + c_0; index ← 0; last ← (count==1); 2A_0 computed by shift and stored.
  - Next state STREAM with valid=1. Latency initiate→valid = 2 cycles.
- STREAM: outputs held stable while valid && !ack.
  - On valid && ack && !last: both terms += 2A_0, index++, last ← (index+1 == count−1). New pair is valid the next cycle, so there are no bubbles.
  - On valid && ack && last: valid←0, done←1 for one cycle, state←IDLE.
- initiate outside IDLE is ignored, as are input changes after latch.
- initiate coincident with the final ack is ignored; it must be reissued in IDLE, so back-to-back sequences have a 1-cycle gap minimum.
- Arithmetic: W-bit two's complement, wrap-around by default. a_0 is zero-extended into the signed domain.

Optional Feature:
- Macro TERM_SATURATE_EN.
- Defined:
  - Each add/subtract saturates to the signed range, +(2^(W−1)−1) or −2^(W−1).
  - Extra output sat_flag (1 bit) is sticky per sequence and cleared at LOAD.
- Undefined: terms wrap; sat_flag port absent.

Decomposition:
- Package ultrasound_delay_pkg:
  - TERM_W localparam.
  - term_t typedef, signed [TERM_W-1:0].
  - seq_state_t enum {IDLE, LOAD, STREAM}.
  - Term saturation min/max constants.
- One sub-module term_accumulator, instantiated twice (pos, neg):
  - Registered term.
  - Load-with-value or add-increment select.
  - Saturation logic under TERM_SATURATE_EN.
- Top level holds FSM, counter, last/valid/done.

Test Plan:
- a_0=132 (16.5), c_0=80 (10.0), num_elements=3, ack held 1 → pairs (52,212),(316,476),(580,740) on 3 consecutive cycles, index 0,1,2, last on 3rd, done the cycle after, valid low.
- Same stimulus, ack toggled 1-0-0-1 → outputs frozen while ack=0, no pair skipped or repeated; total 3 handshakes.
- num_elements=0 → no valid, done pulse 1 cycle after initiate, busy stays 0. num_elements=40 with MAX=32 → exactly 32 pairs, last on index 31.
- initiate pulsed in STREAM with new a_0/c_0 → ignored, sequence continues with original values; initiate on final-ack cycle → ignored.
- rst asserted low mid-STREAM (index=1) → valid/busy/done 0 immediately (async), IDLE after release; new initiate produces index 0 correctly.
- a_0 = 2^(W−2), c_0=−a_0, num_elements=4:
  - TERM_SATURATE_EN defined: term_neg clamps at 2^(W−1)−1, sat_flag=1.
  - TERM_SATURATE_EN undefined: term_neg wraps negative.
